sv_bus_mux_demux_arb: RTL and testbench
=======================================

// Module: sv_bus_mux_demux_arb
// PURPOSE
//  Packet-locked round-robin arbiter sharing the single byte stream into the
//  stream-to-bus demux among N byte-stream sources. Grants one source per
//  packet of PKT_LEN bytes and holds the grant until the last byte transfers.
//  Sits between the N source serializers and the demux str_vld/str_bus/str_rdy port.
// PARAMETERS
//  N        4  number of requesting sources, 2..16
//  PKT_LEN  8  bytes per packet; power of 2, >=2; must equal the demux packet length
// PORTS
//  clk      in   1     clock
//  rst_n    in   1     reset, asynchronous, active-low
//  src_vld  in   N     per-source byte valid
//  src_bus  in   N*8   per-source byte data, source i at [8*i+7:8*i]
//  src_rdy  out  N     per-source ready
//  str_vld  out  1     merged stream valid, to demux
//  str_bus  out  8     merged stream byte, to demux
//  str_rdy  in   1     demux ready
//  gnt_vld  out  1     a packet grant is active
//  gnt_idx  out  IW    granted source index, IW = $clog2(N)
// BEHAVIOUR
//  - Transfer on a port = vld & rdy in the same cycle.
//  - FSM: IDLE, BUSY. Reset state IDLE; gnt_vld=0, gnt_idx=0, byte count=0,
//    last-winner pointer=N-1 so source 0 wins first on a tie.
//  - IDLE: if any src_vld=1, register the winner = first requesting source
//    after last-winner (wrapping N-1 -> 0), gnt_vld<=1, go BUSY. No request: stay.
//  - IDLE outputs: str_vld=0, src_rdy=0 for all sources.
//  - BUSY: str_vld=src_vld[gnt_idx]; str_bus=src_bus[gnt_idx];
//    src_rdy[gnt_idx]=str_rdy; all other src_rdy=0. Purely combinational path.
//  - Byte count (log2(PKT_LEN) bits) increments on each stream transfer and wraps
//    to 0 on the PKT_LEN-th transfer.
//  - That last transfer sets last-winner<=gnt_idx, gnt_vld<=0, and returns to IDLE.
//  - Latency: src_vld rising in IDLE at cycle t -> str_vld may assert at t+1.
//    One idle bubble cycle separates consecutive packets.
//  - Grant is locked for the whole packet. If the granted source drops src_vld
//    mid-packet, the arbiter waits indefinitely (no timeout, no preemption).
//  - Requests from other sources during BUSY are ignored until the next IDLE.
//  - Fairness: with all N sources requesting, grants rotate 0,1,..,N-1,0.
//  - Starvation bound: N-1 packets.
//  - str_rdy low holds the count and grant; str_bus is stable while str_vld & ~str_rdy.
//  - Reset asserted mid-packet: immediate return to IDLE, count=0, pointer=N-1.
//    The demux shares rst so its byte counter realigns; a partial packet is discarded.
//  - gnt_idx holds its last value in IDLE and is valid only when gnt_vld=1.
// STRUCTURE
//  - package_str: add localparam STR_PKT_LEN=8. PKT_LEN defaults to it.
//  - The FSM state enum is local to this module.
//  - Sub-module sv_bus_mux_demux_rr: combinational round-robin picker.
//    Inputs: req[N], ptr[IW]. Outputs: any, idx[IW].
//  - Arbiter top: FSM, counter, pointer, and mux/demux of the handshake.
// TESTING
//  1. Reset, src_vld=4'b0100, str_rdy=1 -> gnt_idx=2 at t+1.
//     8 bytes pass in 8 cycles; gnt_vld=0 after the 8th byte.
//  2. All sources valid, str_rdy=1 -> grant order 0,1,2,3,0.
//     Each packet is exactly 8 transfers; 1 idle cycle between packets.
//  3. Granted source drops src_vld at byte 3 for 5 cycles -> str_vld=0 and
//     other src_rdy=0. Resumes and completes with 8 bytes total.
//  4. str_rdy toggled randomly -> str_bus/str_vld stable while stalled.
//     Demux bus_adr/bus_dat match the source packet bytes in order.
//  5. rst_n pulsed low at byte 5 of a source-1 packet -> IDLE, gnt_vld=0.
//     The next grant goes to source 0 if requesting.
//  6. Source 3 requests alone, then source 0 joins during BUSY -> 3 completes.
//     Next grant goes to 0; no byte from 0 appears during 3's packet.

Source files
------------

// File: rtl/sv_bus_mux_demux_arb_pkg.sv
// Shared constants for the byte-stream arbiter and the stream-to-bus demux.
package sv_bus_mux_demux_arb_pkg;

    localparam int unsigned STR_PKT_LEN = 8;
    localparam int unsigned BYTE_W      = 8;

endpackage

// File: rtl/sv_bus_mux_demux_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module sv_bus_mux_demux_rr #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic          hi_hit;
    logic          lo_hit;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Split search: above ptr takes priority, otherwise wrap to the lowest requester.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && (i > 32'(ptr)) && !hi_hit) begin
                hi_hit = 1'b1;
                hi_idx = IW'(i);
            end
            if (req[i] && (i <= 32'(ptr)) && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = IW'(i);
            end
        end
        any = hi_hit | lo_hit;
        idx = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/sv_bus_mux_demux_arb.sv
// Packet-locked round-robin arbiter merging N byte streams into one demux stream.
module sv_bus_mux_demux_arb
    import sv_bus_mux_demux_arb_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned PKT_LEN = STR_PKT_LEN,
    localparam int unsigned IW     = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          src_vld,
    input  logic [N*BYTE_W-1:0]   src_bus,
    output logic [N-1:0]          src_rdy,
    output logic                  str_vld,
    output logic [BYTE_W-1:0]     str_bus,
    input  logic                  str_rdy,
    output logic                  gnt_vld,
    output logic [IW-1:0]         gnt_idx
);

    localparam int unsigned CW = $clog2(PKT_LEN);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              pick_any;
    logic [IW-1:0]     pick_idx;
    logic [BYTE_W-1:0] src_byte [N];
    logic              xfer;

    sv_bus_mux_demux_rr #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req (src_vld),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            src_byte[i] = src_bus[BYTE_W*i +: BYTE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(N - 1);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        str_vld = 1'b0;
        str_bus = '0;
        src_rdy = '0;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                str_vld        = src_vld[idx_q];
                str_bus        = src_byte[idx_q];
                src_rdy[idx_q] = str_rdy;
                xfer           = str_vld & str_rdy;
                if (xfer) begin
                    // Counter width is log2(PKT_LEN), so the last transfer wraps it to 0.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(PKT_LEN - 1)) begin
                        ptr_d   = idx_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_vld = (state_q == BUSY);
    assign gnt_idx = idx_q;

endmodule

// File: tb/tb_sv_bus_mux_demux_arb.sv
// Directed bench: vector table for the single-source packet, hand sequences for the rest.
module tb_sv_bus_mux_demux_arb;

    localparam int N  = 4;
    localparam int PL = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   src_vld = '0;
    logic [N*8-1:0] src_bus;
    logic [N-1:0]   src_rdy;
    logic           str_vld;
    logic [7:0]     str_bus;
    logic           str_rdy = 1'b0;
    logic           gnt_vld;
    logic [1:0]     gnt_idx;

    int unsigned scnt [N];
    int          passed = 0;
    int          total  = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] vld;
        logic       rdy;
        logic       e_svld;
        logic [7:0] e_bus;
        logic [3:0] e_rdy;
        logic       e_gvld;
        logic [1:0] e_idx;
    } vec_t;

    vec_t tbl [12];

    sv_bus_mux_demux_arb #(
        .N       (N),
        .PKT_LEN (PL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_vld (src_vld),
        .src_bus (src_bus),
        .src_rdy (src_rdy),
        .str_vld (str_vld),
        .str_bus (str_bus),
        .str_rdy (str_rdy),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] src_byte(input int i);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(i);
        lo = 4'(scnt[i]);
        return {hi, lo};
    endfunction

    task automatic update_bus();
        for (int i = 0; i < N; i++) src_bus[8*i +: 8] = src_byte(i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Latch this cycle's handshakes, cross the clock edge, then advance the sources.
    task automatic adv();
        logic [N-1:0] xf;
        xf = src_vld & src_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (xf[i]) scnt[i]++;
        update_bus();
    endtask

    task automatic run_pkt(input int exp);
        @(negedge clk);
        chk("idle_gnt_vld", gnt_vld, 0);
        chk("idle_str_vld", str_vld, 0);
        chk("idle_src_rdy", src_rdy, 0);
        adv();
        for (int k = 0; k < PL; k++) begin
            @(negedge clk);
            chk("pkt_gnt_vld", gnt_vld, 1);
            chk("pkt_gnt_idx", gnt_idx, exp);
            chk("pkt_str_vld", str_vld, 1);
            chk("pkt_str_bus", str_bus, src_byte(exp));
            chk("pkt_src_rdy", src_rdy, 4'b0001 << exp);
            adv();
        end
    endtask

    task automatic set_row(input int r, input logic rs, input logic [3:0] v, input logic rd,
                           input logic esv, input logic [7:0] eb, input logic [3:0] er,
                           input logic egv, input logic [1:0] ei);
        tbl[r] = '{rs, v, rd, esv, eb, er, egv, ei};
    endtask

    initial begin
        int unsigned start;
        int          n;
        bit          done;

        for (int i = 0; i < N; i++) scnt[i] = 0;
        update_bus();

        // Test 1: single source 2, one full packet from reset
        set_row(0, 0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd0);
        set_row(1, 1, 4'b0100, 1, 0, 8'h00, 4'b0000, 0, 2'd0);
        for (int k = 0; k < PL; k++)
            set_row(2 + k, 1, 4'b0100, 1, 1, 8'h20 + 8'(k), 4'b0100, 1, 2'd2);
        set_row(10, 1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd2);
        set_row(11, 1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd2);

        for (int r = 0; r < 12; r++) begin
            rst_n   = tbl[r].rst_n;
            src_vld = tbl[r].vld;
            str_rdy = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("t1_str_vld[%0d]", r), str_vld, tbl[r].e_svld);
            chk($sformatf("t1_str_bus[%0d]", r), str_bus, tbl[r].e_bus);
            chk($sformatf("t1_src_rdy[%0d]", r), src_rdy, tbl[r].e_rdy);
            chk($sformatf("t1_gnt_vld[%0d]", r), gnt_vld, tbl[r].e_gvld);
            chk($sformatf("t1_gnt_idx[%0d]", r), gnt_idx, tbl[r].e_idx);
            adv();
        end

        // Test 2: all requesting after reset -> 0,1,2,3,0
        rst_n = 1'b0;
        @(negedge clk);
        adv();
        rst_n   = 1'b1;
        src_vld = 4'b1111;
        str_rdy = 1'b1;
        run_pkt(0);
        run_pkt(1);
        run_pkt(2);
        run_pkt(3);
        run_pkt(0);

        // Test 3: granted source 1 stalls mid-packet while others request
        src_vld = 4'b0010;
        start   = scnt[1];
        @(negedge clk);
        chk("t3_idle", gnt_vld, 0);
        adv();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_idx", gnt_idx, 1);
            chk("t3_bus", str_bus, src_byte(1));
            adv();
        end
        src_vld = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_gap_str_vld", str_vld, 0);
            chk("t3_gap_src_rdy", src_rdy, 4'b0010);
            chk("t3_gap_gnt", {gnt_vld, gnt_idx}, 3'b101);
            adv();
        end
        src_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_res_vld", str_vld, 1);
            chk("t3_res_bus", str_bus, src_byte(1));
            adv();
        end
        src_vld = 4'b0000;
        @(negedge clk);
        chk("t3_end_gnt_vld", gnt_vld, 0);
        chk("t3_byte_total", scnt[1] - start, PL);
        adv();

        // Test 4: random str_rdy back-pressure on source 2's packet
        src_vld = 4'b1111;
        start   = scnt[2];
        n       = 0;
        done    = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            str_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (n == PL) begin
                chk("t4_end_gnt_vld", gnt_vld, 0);
                src_vld = 4'b0000;
                done    = 1'b1;
            end else if (gnt_vld) begin
                chk("t4_idx", gnt_idx, 2);
                chk("t4_str_vld", str_vld, 1);
                chk("t4_bus", str_bus, src_byte(2));
                chk("t4_src_rdy", src_rdy, {1'b0, str_rdy, 2'b00});
            end
            adv();
            n = int'(scnt[2] - start);
        end
        if (!done) chk("t4_timeout", 0, 1);
        str_rdy = 1'b1;

        // Test 5: reset mid-packet of source 1, then source 0 wins
        src_vld = 4'b0010;
        @(negedge clk);
        chk("t5_idle", gnt_vld, 0);
        adv();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_idx", gnt_idx, 1);
            chk("t5_bus", str_bus, src_byte(1));
            adv();
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_gnt_vld", gnt_vld, 0);
        chk("t5_rst_str_vld", str_vld, 0);
        chk("t5_rst_src_rdy", src_rdy, 0);
        adv();
        rst_n   = 1'b1;
        src_vld = 4'b0011;
        run_pkt(0);

        // Test 6: source 3 alone, source 0 joins during the packet
        src_vld = 4'b1000;
        start   = scnt[0];
        @(negedge clk);
        chk("t6_idle", gnt_vld, 0);
        adv();
        for (int k = 0; k < PL; k++) begin
            if (k == 2) src_vld = 4'b1001;
            @(negedge clk);
            chk("t6_idx", gnt_idx, 3);
            chk("t6_bus", str_bus, src_byte(3));
            chk("t6_src_rdy", src_rdy, 4'b1000);
            adv();
        end
        chk("t6_no_src0_bytes", scnt[0] - start, 0);
        @(negedge clk);
        chk("t6_gap", gnt_vld, 0);
        adv();
        @(negedge clk);
        chk("t6_next_gnt", {gnt_vld, gnt_idx}, 3'b100);
        chk("t6_next_bus", str_bus, src_byte(0));
        adv();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
